calendar_date: RTL and testbench

CALENDAR_DATE -- requirements
Module: calendar_date

---
 rtl/calendar_date.sv | 116 +++++++++++
 tb/tb_calendar_date.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date.sv
// Calendar date stage: keeps day/month/year (2000 + offset), advances on the daily tick, accepts checked loads.
// Optional: define CALENDAR_LEAP_YEAR_EN to give February 29 days when year[1:0] == 0.
module calendar_date #(
  parameter int YEAR_MAX = 99
) (
  input  logic        clk,
  input  logic        clear_n,
  input  logic        tick,
  input  logic        load,
  input  logic [4:0]  ld_date,
  input  logic [3:0]  ld_month,
  input  logic [6:0]  ld_year,
  input  logic        enable,
  output logic [4:0]  date,
  output logic [3:0]  month,
  output logic [6:0]  year,
  output logic        day_adv,
  output logic        year_wrap,
  output logic        load_err,
  output logic [15:0] databus
);

  localparam logic [6:0] YEAR_LAST = 7'(YEAR_MAX);

  // February length depends only on the leap flag.
  function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
      4'd2:                    days_in_month = leap ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  logic cur_leap, ld_leap;
`ifdef CALENDAR_LEAP_YEAR_EN
  assign cur_leap = (year[1:0] == 2'b00);
  assign ld_leap  = (ld_year[1:0] == 2'b00);
`else
  assign cur_leap = 1'b0;
  assign ld_leap  = 1'b0;
`endif

  logic [4:0] cur_dim, ld_dim;
  logic       ld_ok;

  assign cur_dim = days_in_month(month, cur_leap);
  assign ld_dim  = days_in_month(ld_month, ld_leap);
  assign ld_ok   = (ld_month >= 4'd1) && (ld_month <= 4'd12) &&
                   (ld_date != 5'd0) && (ld_date <= ld_dim) &&
                   (ld_year <= YEAR_LAST);

  logic [4:0] date_d;
  logic [3:0] month_d;
  logic [6:0] year_d;
  logic       day_adv_d, year_wrap_d, load_err_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    date_d      = date;
    month_d     = month;
    year_d      = year;
    day_adv_d   = 1'b0;
    year_wrap_d = 1'b0;
    load_err_d  = 1'b0;
    if (load) begin
      // A load always wins; a coincident tick is dropped.
      if (ld_ok) begin
        date_d  = ld_date;
        month_d = ld_month;
        year_d  = ld_year;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      day_adv_d = 1'b1;
      if (date < cur_dim) begin
        date_d = date + 5'd1;
      end else begin
        date_d = 5'd1;
        if (month == 4'd12) begin
          month_d = 4'd1;
          if (year == YEAR_LAST) begin
            year_d      = 7'd0;
            year_wrap_d = 1'b1;
          end else begin
            year_d = year + 7'd1;
          end
        end else begin
          month_d = month + 4'd1;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all fields update together on the edge.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      date      <= 5'd1;
      month     <= 4'd1;
      year      <= 7'd0;
      day_adv   <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      date      <= date_d;
      month     <= month_d;
      year      <= year_d;
      day_adv   <= day_adv_d;
      year_wrap <= year_wrap_d;
      load_err  <= load_err_d;
    end
  end

  assign databus = enable ? {year, month, date} : 16'd0;

endmodule

// File: tb/tb_calendar_date.sv
// Self-checking bench for calendar_date: directed scenarios plus random tick/load traffic
// compared against an integer calendar model.
module tb_calendar_date;

  localparam int YEAR_MAX = 99;

  logic        clk = 1'b0;
  logic        clear_n;
  logic        tick, load, enable;
  logic [4:0]  ld_date;
  logic [3:0]  ld_month;
  logic [6:0]  ld_year;
  logic [4:0]  date;
  logic [3:0]  month;
  logic [6:0]  year;
  logic        day_adv, year_wrap, load_err;
  logic [15:0] databus;

  calendar_date #(.YEAR_MAX(YEAR_MAX)) dut (
    .clk(clk), .clear_n(clear_n), .tick(tick), .load(load),
    .ld_date(ld_date), .ld_month(ld_month), .ld_year(ld_year), .enable(enable),
    .date(date), .month(month), .year(year),
    .day_adv(day_adv), .year_wrap(year_wrap), .load_err(load_err), .databus(databus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int adv_count = 0;

  // Reference model: plain integers, calendar rules applied directly.
  int m_d, m_m, m_y;
  int m_adv, m_wrap, m_err;
  int month_len [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  function automatic int model_dim(int m, int y);
    int n;
    if (m < 1 || m > 12) return 0;
    n = month_len[m - 1];
`ifdef CALENDAR_LEAP_YEAR_EN
    if (m == 2 && (y % 4) == 0) n = 29;
`endif
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_d = 1; m_m = 1; m_y = 0; m_adv = 0; m_wrap = 0; m_err = 0;
  endtask

  task automatic model_step();
    int ld_d, ld_m, ld_y;
    m_adv = 0; m_wrap = 0; m_err = 0;
    ld_d = int'(ld_date); ld_m = int'(ld_month); ld_y = int'(ld_year);
    if (load) begin
      if (ld_m >= 1 && ld_m <= 12 && ld_d >= 1 && ld_d <= model_dim(ld_m, ld_y) && ld_y <= YEAR_MAX) begin
        m_d = ld_d; m_m = ld_m; m_y = ld_y;
      end else begin
        m_err = 1;
      end
    end else if (tick) begin
      m_adv = 1;
      m_d++;
      if (m_d > model_dim(m_m, m_y)) begin
        m_d = 1;
        m_m++;
        if (m_m > 12) begin
          m_m = 1;
          m_y++;
          if (m_y > YEAR_MAX) begin
            m_y = 0;
            m_wrap = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("date", int'(date), m_d);
    check("month", int'(month), m_m);
    check("year", int'(year), m_y);
    check("day_adv", int'(day_adv), m_adv);
    check("year_wrap", int'(year_wrap), m_wrap);
    check("load_err", int'(load_err), m_err);
    check("databus", int'(databus), enable ? (m_y * 512 + m_m * 32 + m_d) : 0);
  endtask

  // Inputs are set at a falling edge; one rising edge is applied and results checked at the next falling edge.
  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (day_adv) adv_count++;
    check_all();
  endtask

  task automatic do_load(input int d, input int m, input int y, input logic t);
    load = 1'b1; tick = t;
    ld_date = 5'(d); ld_month = 4'(m); ld_year = 7'(y);
    cycle();
    load = 1'b0; tick = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
  endtask

  initial begin
    clear_n = 1'b0; tick = 1'b0; load = 1'b0; enable = 1'b1;
    ld_date = '0; ld_month = '0; ld_year = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    clear_n = 1'b1;

    // 31 ticks from reset land on 1 February 2000.
    adv_count = 0;
    for (int i = 0; i < 31; i++) do_tick();
    check("jan_end_date", int'(date), 1);
    check("jan_end_month", int'(month), 2);
    check("jan_day_adv_count", adv_count, 31);

    // February end: 2024 is leap only when the feature is built in; 2023 never is.
    do_load(28, 2, 24, 1'b0);
    do_tick();
`ifdef CALENDAR_LEAP_YEAR_EN
    check("feb24_date", int'(date), 29);
`else
    check("feb24_month", int'(month), 3);
`endif
    do_load(28, 2, 23, 1'b0);
    do_tick();
    check("feb23_month", int'(month), 3);

    // Century wrap.
    do_load(31, 12, 99, 1'b0);
    do_tick();
    check("wrap_pulse", int'(year_wrap), 1);
    check("wrap_year", int'(year), 0);
    tick = 1'b0;
    cycle();
    check("wrap_pulse_one_cycle", int'(year_wrap), 0);

    // Rejected loads.
    do_load(31, 4, 10, 1'b0);
    check("err_apr31", int'(load_err), 1);
    do_load(0, 5, 10, 1'b0);
    check("err_date0", int'(load_err), 1);
    do_load(15, 13, 10, 1'b0);
    check("err_month13", int'(load_err), 1);
    do_load(29, 2, 23, 1'b0);
    check("err_feb29_23", int'(load_err), 1);
    do_load(1, 1, 100, 1'b0);
    check("err_year100", int'(load_err), 1);

    // Load beats a coincident tick; databus gating.
    do_load(10, 6, 30, 1'b1);
    check("ld_tick_no_adv", int'(day_adv), 0);
    enable = 1'b0;
    cycle();
    check("bus_off", int'(databus), 0);
    enable = 1'b1;
    cycle();
    check("bus_on", int'(databus), (30 << 9) | (6 << 5) | 10);

    // Reset in the middle of a tick cycle discards the tick.
    do_load(15, 8, 45, 1'b0);
    tick = 1'b1;
    #2 clear_n = 1'b0;
    #1;
    model_reset();
    check_all();
    tick = 1'b0;
    @(negedge clk);
    clear_n = 1'b1;
    cycle();
    check("post_reset_no_adv", int'(day_adv), 0);

    // Random traffic, loads biased towards month and century ends.
    for (int i = 0; i < 3000; i++) begin
      enable = 1'($urandom_range(0, 3) != 0);
      tick   = 1'($urandom_range(0, 9) < 7);
      load   = 1'($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        ld_date  = 5'($urandom_range(27, 31));
        ld_month = 4'($urandom_range(11, 12));
        ld_year  = 7'($urandom_range(97, 100));
      end else begin
        ld_date  = 5'($urandom_range(0, 31));
        ld_month = 4'($urandom_range(0, 15));
        ld_year  = 7'($urandom_range(0, 127));
      end
      cycle();
    end
    tick = 1'b0; load = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
